hazard_forward_ctrl: RTL and testbench

- Hazard and forwarding controller for the RV32IF 5-stage pipeline.
- Sits upstream of the EX-stage forwarding operand muxes and drives their 2-bit select controls from flops, so the mux controls are glitch-free and cost no EX-stage decode timing.
- Also generates load-use stalls, branch flushes and multi-cycle FDIV/FSQRT EX-hold sequencing.

---
 rtl/hazard_forward_ctrl_pkg.sv | 17 +
 rtl/hazard_forward_ctrl_long_op_counter.sv | 62 ++++++
 rtl/hazard_forward_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings and latency defaults for the RV32IF hazard/forwarding controller.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_WB    = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    localparam int FDIV_LAT_DEF  = 12;
    localparam int FSQRT_LAT_DEF = 16;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic {
        LONG_IDLE = 1'b0,
        LONG_BUSY = 1'b1
    } long_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_long_op_counter.sv
// Multi-cycle FDIV/FSQRT EX-hold sequencer: holds EX for LAT-1 cycles, releasing on the result cycle.
// state     | meaning
// LONG_IDLE | no long op in flight; a start issues and begins holding
// LONG_BUSY | counting down; hold while count != 0, release at 0
module long_op_counter
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int FDIV_LAT  = FDIV_LAT_DEF,
    parameter int FSQRT_LAT = FSQRT_LAT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic sqrt,
    output logic ex_hold,
    output logic busy
);

    long_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LONG_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_hold = 1'b0;
        if (!rst) begin
            unique case (state_q)
                LONG_IDLE: begin
                    if (start) begin
                        ex_hold = 1'b1;
                        cnt_d   = sqrt ? CNT_W'(FSQRT_LAT - 2) : CNT_W'(FDIV_LAT - 2);
                        state_d = LONG_BUSY;
                    end
                end
                LONG_BUSY: begin
                    // start stays high while the op sits in EX, so it is ignored here
                    if (cnt_q != '0) begin
                        ex_hold = 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        state_d = LONG_IDLE;
                    end
                end
                default: state_d = LONG_IDLE;
            endcase
        end
    end

    assign busy = (state_q == LONG_BUSY);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand-forward select registers plus load-use stall, branch flush and long-op hold control.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int FDIV_LAT  = FDIV_LAT_DEF,
    parameter int FSQRT_LAT = FSQRT_LAT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_fp,
    input  logic       id_rs2_fp,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rd_fp,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic       ex_long_start,
    input  logic       ex_long_sqrt,
    input  logic [4:0] mem_rd,
    input  logic       mem_rd_fp,
    input  logic       mem_reg_write,
    input  logic       branch_taken,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_hold,
    output logic       ex_mem_flush,
    output logic       long_busy
);

    // Integer x0 never matches; FP f0 is a real register.
    function automatic logic src_match(input logic used, input logic [4:0] rs, input logic rs_fp,
                                       input logic wr, input logic [4:0] rd, input logic rd_fp);
        return used && wr && (rs_fp == rd_fp) && (rs == rd) && (rs_fp || (rs != 5'd0));
    endfunction

    function automatic logic [1:0] sel_next(input logic m_ex, input logic m_mem, input logic ex_load);
        if (m_ex && !ex_load) return FWD_EXMEM;
        if (m_mem)            return FWD_WB;
        return FWD_RF;
    endfunction

    logic       a_ex, a_mem, b_ex, b_mem;
    logic       load_use;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    long_op_counter #(
        .FDIV_LAT  (FDIV_LAT),
        .FSQRT_LAT (FSQRT_LAT),
        .CNT_W     (CNT_W)
    ) u_long (
        .clk     (clk),
        .rst     (rst),
        .start   (ex_long_start),
        .sqrt    (ex_long_sqrt),
        .ex_hold (ex_hold),
        .busy    (long_busy)
    );

    assign a_ex  = src_match(id_rs1_used, id_rs1, id_rs1_fp, ex_reg_write,  ex_rd,  ex_rd_fp);
    assign a_mem = src_match(id_rs1_used, id_rs1, id_rs1_fp, mem_reg_write, mem_rd, mem_rd_fp);
    assign b_ex  = src_match(id_rs2_used, id_rs2, id_rs2_fp, ex_reg_write,  ex_rd,  ex_rd_fp);
    assign b_mem = src_match(id_rs2_used, id_rs2, id_rs2_fp, mem_reg_write, mem_rd, mem_rd_fp);

    assign load_use = (a_ex || b_ex) && ex_mem_read;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (ex_hold) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (branch_taken) begin
            // Branch beats load-use: the stalled instruction is wrong-path anyway.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a_d = sel_next(a_ex, a_mem, ex_mem_read);
        fwd_b_d = sel_next(b_ex, b_mem, ex_mem_read);
        if (ex_hold) begin
            fwd_a_d = fwd_a_q;
            fwd_b_d = fwd_b_q;
        end else if (id_ex_flush) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl with hand-computed expectations.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_rs1_fp, id_rs2_fp, id_rs1_used, id_rs2_used;
    logic       ex_rd_fp, ex_reg_write, ex_mem_read, ex_long_start, ex_long_sqrt;
    logic       mem_rd_fp, mem_reg_write, branch_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_hold, ex_mem_flush, long_busy;

    int errors = 0;
    int checks = 0;
    int hold_cnt;

    always #5 clk = ~clk;

    hazard_forward_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_fp     (id_rs1_fp),
        .id_rs2_fp     (id_rs2_fp),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_rd         (ex_rd),
        .ex_rd_fp      (ex_rd_fp),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_long_start (ex_long_start),
        .ex_long_sqrt  (ex_long_sqrt),
        .mem_rd        (mem_rd),
        .mem_rd_fp     (mem_rd_fp),
        .mem_reg_write (mem_reg_write),
        .branch_taken  (branch_taken),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_hold       (ex_hold),
        .ex_mem_flush  (ex_mem_flush),
        .long_busy     (long_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_fp = 1'b0; id_rs2_fp = 1'b0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_rd_fp = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_long_start = 1'b0; ex_long_sqrt = 1'b0;
        mem_rd = 5'd0; mem_rd_fp = 1'b0; mem_reg_write = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic run_long(input logic sqrt, input int exp_hold, input string tag);
        ex_rd = 5'd9; ex_rd_fp = 1'b0; ex_reg_write = 1'b1;
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        step();
        check_eq({tag, "_presel"}, 32'(fwd_a_sel), 32'd2);
        ex_reg_write = 1'b0; id_rs1 = 5'd0;
        ex_long_start = 1'b1; ex_long_sqrt = sqrt; branch_taken = 1'b1;
        #1;
        hold_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ex_hold) break;
            hold_cnt++;
            check_eq({tag, "_pc_stall"}, 32'(pc_stall), 32'd1);
            check_eq({tag, "_ex_mem_flush"}, 32'(ex_mem_flush), 32'd1);
            check_eq({tag, "_if_id_flush"}, 32'(if_id_flush), 32'd0);
            check_eq({tag, "_sel_held"}, 32'(fwd_a_sel), 32'd2);
            step();
        end
        branch_taken = 1'b0;
        check_eq({tag, "_hold_cycles"}, 32'(hold_cnt), 32'(exp_hold));
        check_eq({tag, "_release_busy"}, 32'(long_busy), 32'd1);
        check_eq({tag, "_release_stall"}, 32'(pc_stall), 32'd0);
        ex_long_start = 1'b0;
        step();
        check_eq({tag, "_idle"}, 32'(long_busy), 32'd0);
        check_eq({tag, "_post_hold"}, 32'(ex_hold), 32'd0);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        branch_taken = 1'b1;
        ex_long_start = 1'b1;
        #1;
        check_eq("rst_if_id_flush", 32'(if_id_flush), 32'd0);
        check_eq("rst_ex_hold", 32'(ex_hold), 32'd0);
        step();
        step();
        check_eq("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        check_eq("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        check_eq("rst_long_busy", 32'(long_busy), 32'd0);
        clear_inputs();
        rst = 1'b0;
        step();

        // EX producer forwarding
        ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        check_eq("ex_fwd_no_stall", 32'(pc_stall), 32'd0);
        step();
        check_eq("ex_fwd_a", 32'(fwd_a_sel), 32'd2);
        check_eq("ex_fwd_b", 32'(fwd_b_sel), 32'd0);
        clear_inputs();

        // EX beats MEM, then MEM alone
        ex_rd = 5'd5; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1;
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        step();
        check_eq("ex_over_mem_b", 32'(fwd_b_sel), 32'd2);
        ex_reg_write = 1'b0;
        step();
        check_eq("mem_only_b", 32'(fwd_b_sel), 32'd1);
        id_rs2_used = 1'b0;
        step();
        check_eq("unused_src_b", 32'(fwd_b_sel), 32'd0);
        clear_inputs();

        // x0, f0, and class mismatch
        ex_rd = 5'd0; ex_reg_write = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        step();
        check_eq("x0_no_match", 32'(fwd_a_sel), 32'd0);
        ex_rd_fp = 1'b1; id_rs1_fp = 1'b1;
        step();
        check_eq("f0_match", 32'(fwd_a_sel), 32'd2);
        ex_rd = 5'd3; ex_rd_fp = 1'b1; id_rs1 = 5'd3; id_rs1_fp = 1'b0;
        step();
        check_eq("x3_vs_f3", 32'(fwd_a_sel), 32'd0);
        clear_inputs();

        // Load-use stall, then MEM forward
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs1 = 5'd7; id_rs1_used = 1'b1;
        #1;
        check_eq("lu_pc_stall", 32'(pc_stall), 32'd1);
        check_eq("lu_if_id_stall", 32'(if_id_stall), 32'd1);
        check_eq("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check_eq("lu_if_id_flush", 32'(if_id_flush), 32'd0);
        check_eq("lu_ex_mem_flush", 32'(ex_mem_flush), 32'd0);
        step();
        check_eq("lu_sel_zero", 32'(fwd_a_sel), 32'd0);
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_rd = 5'd7; mem_reg_write = 1'b1;
        #1;
        check_eq("lu_next_no_stall", 32'(pc_stall), 32'd0);
        step();
        check_eq("lu_next_sel_mem", 32'(fwd_a_sel), 32'd1);
        clear_inputs();
        step();

        run_long(1'b0, 11, "fdiv");
        run_long(1'b1, 15, "fsqrt");

        // Branch coincident with load-use
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs1 = 5'd7; id_rs1_used = 1'b1; branch_taken = 1'b1;
        #1;
        check_eq("br_if_id_flush", 32'(if_id_flush), 32'd1);
        check_eq("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check_eq("br_pc_stall", 32'(pc_stall), 32'd0);
        check_eq("br_if_id_stall", 32'(if_id_stall), 32'd0);
        clear_inputs();
        step();

        // Reset in the 5th BUSY cycle
        ex_rd = 5'd9; ex_reg_write = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
        step();
        ex_reg_write = 1'b0;
        ex_long_start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check_eq("mid_busy", 32'(long_busy), 32'd1);
        check_eq("mid_hold", 32'(ex_hold), 32'd1);
        rst = 1'b1;
        ex_long_start = 1'b0;
        #1;
        check_eq("mid_rst_hold_forced", 32'(ex_hold), 32'd0);
        check_eq("mid_rst_stall_forced", 32'(pc_stall), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("post_rst_busy", 32'(long_busy), 32'd0);
        check_eq("post_rst_hold", 32'(ex_hold), 32'd0);
        check_eq("post_rst_pc_stall", 32'(pc_stall), 32'd0);
        check_eq("post_rst_ex_mem_flush", 32'(ex_mem_flush), 32'd0);
        check_eq("post_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        step();
        check_eq("post_rst_stays_idle", 32'(long_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
